alu16_fault_inj: RTL and testbench
==================================

Name: alu16_fault_inj

Overview:
- 16-bit ALU with stuck-at fault injection on operand a. Computes a fault-free (golden) result and a faulted result in parallel, registers both, and flags any mismatch.
- Serves as the DUT-side core of the ATPG / fault-coverage flow. A pattern is applied, the fault mask is set, and detection is read back one cycle later.

Parameters:
- WIDTH, 16, operand/result width; all widths below assume 16.
- CNT_W, 16, width of the detection counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and fault controls valid this cycle.
- a  input  16  operand A (fault-injectable).
- b  input  16  operand B.
- alu_sel  input  2  operation select.
- fault_mask_a  input  16  1 = bit of a is forced.
- fault_value_a  input  16  forced value for masked bits; ignored where mask=0.
- result_golden  output  16  registered fault-free result.
- cout_golden  output  1  registered fault-free carry.
- result  output  16  registered faulted result.
- cout  output  1  registered faulted carry.
- out_valid  output  1  registered copy of in_valid.
- mismatch  output  1  registered; 1 when {cout,result} != {cout_golden,result_golden} and out_valid.
- detect_count  output  CNT_W  count of mismatch cycles; saturates.

Behaviour:
- Effective operand: a_f = (a & ~fault_mask_a) | (fault_value_a & fault_mask_a). Golden path uses raw a; faulted path uses a_f. b is the same for both paths.
- alu_sel encoding (identical for both paths):
  - 00 AND: result = a & b, cout = 0.
  - 01 OR: result = a | b, cout = 0.
  - 10 ADD: {cout,result} = a + b (17-bit).
  - 11 SUB: {cout,result} = a + ~b + 1 (17-bit). cout = 1 means no borrow (a >= b unsigned).
- Wrap-around: result is modulo 2^16; overflow appears only in cout.
- Latency: exactly 1 cycle. Outputs update every cycle from the current inputs, whatever in_valid is.
- out_valid is a registered copy of in_valid.
- mismatch is computed combinationally from the two path results and registered alongside them. It is forced to 0 when in_valid was 0.
- detect_count increments by 1 on each cycle where the registered mismatch is 1. It saturates at all-ones with no wrap.
- Reset (rst=1 at clock edge): result, result_golden = 0; cout, cout_golden = 0; out_valid = 0; mismatch = 0; detect_count = 0. Reset overrides in_valid in the same cycle. Reset mid-stream discards the in-flight result.
- fault_mask_a = 0 makes both paths bit-identical for every operation, so mismatch = 0 always.
- A masked bit whose forced value equals the applied a bit is undetectable for that pattern. mismatch = 0 in that case is correct behaviour, not an error.
- No handshake backpressure: one result per cycle, always accepted.

Optional Feature:
- FAULT_B_EN: when defined, adds input ports fault_mask_b[15:0] and fault_value_b[15:0]. The faulted path then uses b_f = (b & ~fault_mask_b) | (fault_value_b & fault_mask_b), with identical forcing semantics. The golden path still uses raw b.
- When FAULT_B_EN is undefined, those ports do not exist and the faulted path uses raw b.

Test Plan:
- Reset then no fault: rst 1 cycle; a=AAAA, b=5555, sel=10, mask=0, in_valid=1 → next cycle result=result_golden=FFFF, cout=0, mismatch=0, detect_count=0.
- Undetectable SA1: same pattern, mask=0020, value=0020 (a[5] is already 1) → result=FFFF, mismatch=0, detect_count unchanged.
- Detected SA0: same pattern, mask=0020, value=0000 → result=FFDF, result_golden=FFFF, mismatch=1, detect_count increments by 1.
- Carry/SUB: a=FFFF, b=0001, sel=10 → result=0000, cout=1. Then a=0001, b=0002, sel=11 → result=FFFF, cout=0. With mask=0, mismatch=0 in both cases.
- Sweep: for i=0..15, random a/b with ADD, inject SA0 then SA1 on a[i] → mismatch=1 exactly when the forced value differs from a[i]. detect_count equals the number of mismatches. Drive detect_count to all-ones and confirm it holds.
- Mid-stream reset: assert rst while in_valid=1 with a detected fault active → next cycle all outputs 0 and detect_count=0.

Source files
------------

// File: rtl/alu16_fault_inj_if.sv
// Bus interface for alu16_fault_inj: pattern/fault controls in, golden and
// faulted results out. The b-side fault controls exist only when FAULT_B_EN
// is defined.
interface alu16_fault_inj_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       alu_sel;
    logic [WIDTH-1:0] fault_mask_a;
    logic [WIDTH-1:0] fault_value_a;
`ifdef FAULT_B_EN
    logic [WIDTH-1:0] fault_mask_b;
    logic [WIDTH-1:0] fault_value_b;
`endif
    logic [WIDTH-1:0] result_golden;
    logic             cout_golden;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             out_valid;
    logic             mismatch;
    logic [CNT_W-1:0] detect_count;

    // Pattern source side (testbench / ATPG driver)
    modport master (
        output in_valid, a, b, alu_sel, fault_mask_a, fault_value_a,
`ifdef FAULT_B_EN
        output fault_mask_b, fault_value_b,
`endif
        input  result_golden, cout_golden, result, cout, out_valid, mismatch, detect_count
    );

    // ALU core side
    modport slave (
        input  in_valid, a, b, alu_sel, fault_mask_a, fault_value_a,
`ifdef FAULT_B_EN
        input  fault_mask_b, fault_value_b,
`endif
        output result_golden, cout_golden, result, cout, out_valid, mismatch, detect_count
    );
endinterface

// File: rtl/alu16_fault_inj.sv
// 16-bit ALU with stuck-at fault injection on operand a. A golden and a
// faulted path are evaluated in parallel, registered together, and any
// difference is flagged and counted (saturating).
// Optional: define FAULT_B_EN to also allow forcing bits of operand b.
module alu16_fault_inj #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    alu16_fault_inj_if.slave bus
);
    // Shared ALU evaluation: returns {cout, result}
    function automatic logic [WIDTH:0] alu_eval(input logic [WIDTH-1:0] op_a,
                                                input logic [WIDTH-1:0] op_b,
                                                input logic [1:0]       sel);
        logic [WIDTH:0] r;
        unique case (sel)
            2'b00:   r = {1'b0, op_a & op_b};
            2'b01:   r = {1'b0, op_a | op_b};
            2'b10:   r = {1'b0, op_a} + {1'b0, op_b};
            default: r = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] a_f;
    logic [WIDTH-1:0] b_f;
    logic [WIDTH:0]   golden_d;
    logic [WIDTH:0]   faulted_d;
    logic             mismatch_d;

    logic [WIDTH-1:0] result_golden_q;
    logic             cout_golden_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             out_valid_q;
    logic             mismatch_q;
    logic [CNT_W-1:0] detect_count_q;

    // Apply fault forcing and evaluate both paths
    always_comb begin
        a_f = (bus.a & ~bus.fault_mask_a) | (bus.fault_value_a & bus.fault_mask_a);
`ifdef FAULT_B_EN
        b_f = (bus.b & ~bus.fault_mask_b) | (bus.fault_value_b & bus.fault_mask_b);
`else
        b_f = bus.b;
`endif
        golden_d   = alu_eval(bus.a, bus.b, bus.alu_sel);
        faulted_d  = alu_eval(a_f, b_f, bus.alu_sel);
        // Only valid patterns may report a detection
        mismatch_d = bus.in_valid && (golden_d != faulted_d);
    end

    // Register both paths every cycle regardless of in_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            result_golden_q <= '0;
            cout_golden_q   <= 1'b0;
            result_q        <= '0;
            cout_q          <= 1'b0;
            out_valid_q     <= 1'b0;
            mismatch_q      <= 1'b0;
        end else begin
            {cout_golden_q, result_golden_q} <= golden_d;
            {cout_q, result_q}               <= faulted_d;
            out_valid_q                      <= bus.in_valid;
            mismatch_q                       <= mismatch_d;
        end
    end

    // Saturating count of registered detections (lags mismatch by one cycle)
    always_ff @(posedge clk) begin
        if (rst) begin
            detect_count_q <= '0;
        end else if (mismatch_q && (detect_count_q != {CNT_W{1'b1}})) begin
            detect_count_q <= detect_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.result_golden = result_golden_q;
    assign bus.cout_golden   = cout_golden_q;
    assign bus.result        = result_q;
    assign bus.cout          = cout_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.mismatch      = mismatch_q;
    assign bus.detect_count  = detect_count_q;
endmodule

// File: tb/tb_alu16_fault_inj.sv
// Directed self-checking bench for alu16_fault_inj.
module tb_alu16_fault_inj;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    // Expected detect_count and the previously expected mismatch
    logic [15:0] exp_cnt = 16'h0000;
    logic        prev_mm = 1'b0;

    always #5 clk = ~clk;

    alu16_fault_inj_if #(.WIDTH(16), .CNT_W(16)) bus ();

    alu16_fault_inj #(.WIDTH(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drive one pattern, clock it in, and sample 1 ns after the edge.
    // em is the bench's expected mismatch for this pattern.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] sel, input logic [15:0] m, input logic [15:0] fv,
                         input logic em);
        bus.in_valid      = v;
        bus.a             = a;
        bus.b             = b;
        bus.alu_sel       = sel;
        bus.fault_mask_a  = m;
        bus.fault_value_a = fv;
`ifdef FAULT_B_EN
        bus.fault_mask_b  = 16'h0000;
        bus.fault_value_b = 16'h0000;
`endif
        @(posedge clk);
        #1;
        if (rst) begin
            exp_cnt = 16'h0000;
            prev_mm = 1'b0;
        end else begin
            if (prev_mm && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h0001;
            prev_mm = em;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b1, 16'hAAAA, 16'h5555, 2'b10, 16'h0020, 16'h0000, 1'b0);
        tests++;
        if ({bus.result, bus.cout, bus.result_golden, bus.cout_golden} !== 34'h0) begin
            fails++;
            $display("FAIL reset_results: got %h/%b/%h/%b want 0", bus.result, bus.cout,
                     bus.result_golden, bus.cout_golden);
        end
        tests++;
        if ({bus.out_valid, bus.mismatch} !== 2'b00 || bus.detect_count !== 16'h0000) begin
            fails++;
            $display("FAIL reset_flags: got ov=%b mm=%b cnt=%h want 0/0/0000",
                     bus.out_valid, bus.mismatch, bus.detect_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_no_fault();
        cycle(1'b1, 16'hAAAA, 16'h5555, 2'b10, 16'h0000, 16'h0000, 1'b0);
        tests++;
        if (bus.result !== 16'hFFFF || bus.result_golden !== 16'hFFFF || bus.cout !== 1'b0) begin
            fails++;
            $display("FAIL no_fault_add: got %h/%h c=%b want FFFF/FFFF c=0", bus.result,
                     bus.result_golden, bus.cout);
        end
        tests++;
        if (bus.mismatch !== 1'b0 || bus.out_valid !== 1'b1 || bus.detect_count !== 16'h0000) begin
            fails++;
            $display("FAIL no_fault_flags: got mm=%b ov=%b cnt=%h want 0/1/0000",
                     bus.mismatch, bus.out_valid, bus.detect_count);
        end
    endtask

    task automatic test_undetectable();
        cycle(1'b1, 16'hAAAA, 16'h5555, 2'b10, 16'h0020, 16'h0020, 1'b0);
        tests++;
        if (bus.result !== 16'hFFFF || bus.mismatch !== 1'b0 || bus.detect_count !== exp_cnt) begin
            fails++;
            $display("FAIL undetectable_sa1: got %h mm=%b cnt=%h want FFFF mm=0 cnt=%h",
                     bus.result, bus.mismatch, bus.detect_count, exp_cnt);
        end
    endtask

    task automatic test_detected();
        cycle(1'b1, 16'hAAAA, 16'h5555, 2'b10, 16'h0020, 16'h0000, 1'b1);
        tests++;
        if (bus.result !== 16'hFFDF || bus.result_golden !== 16'hFFFF || bus.mismatch !== 1'b1) begin
            fails++;
            $display("FAIL detected_sa0: got %h/%h mm=%b want FFDF/FFFF mm=1", bus.result,
                     bus.result_golden, bus.mismatch);
        end
        cycle(1'b1, 16'hAAAA, 16'h5555, 2'b10, 16'h0000, 16'h0000, 1'b0);
        tests++;
        if (bus.detect_count !== 16'h0001 || bus.mismatch !== 1'b0) begin
            fails++;
            $display("FAIL detected_count: got cnt=%h mm=%b want 0001 mm=0",
                     bus.detect_count, bus.mismatch);
        end
    endtask

    task automatic test_ops();
        cycle(1'b1, 16'hFFFF, 16'h0001, 2'b10, 16'h0000, 16'h0000, 1'b0);
        tests++;
        if (bus.result !== 16'h0000 || bus.cout !== 1'b1 || bus.cout_golden !== 1'b1
            || bus.mismatch !== 1'b0) begin
            fails++;
            $display("FAIL add_carry: got %h c=%b cg=%b mm=%b want 0000 c=1 cg=1 mm=0",
                     bus.result, bus.cout, bus.cout_golden, bus.mismatch);
        end
        cycle(1'b1, 16'h0001, 16'h0002, 2'b11, 16'h0000, 16'h0000, 1'b0);
        tests++;
        if (bus.result !== 16'hFFFF || bus.cout !== 1'b0 || bus.mismatch !== 1'b0) begin
            fails++;
            $display("FAIL sub_borrow: got %h c=%b mm=%b want FFFF c=0 mm=0",
                     bus.result, bus.cout, bus.mismatch);
        end
        cycle(1'b1, 16'h0005, 16'h0003, 2'b11, 16'h0000, 16'h0000, 1'b0);
        tests++;
        if (bus.result !== 16'h0002 || bus.cout !== 1'b1) begin
            fails++;
            $display("FAIL sub_noborrow: got %h c=%b want 0002 c=1", bus.result, bus.cout);
        end
        cycle(1'b1, 16'hF0F0, 16'hFF00, 2'b00, 16'h0000, 16'h0000, 1'b0);
        tests++;
        if (bus.result !== 16'hF000 || bus.cout !== 1'b0) begin
            fails++;
            $display("FAIL and_op: got %h c=%b want F000 c=0", bus.result, bus.cout);
        end
        cycle(1'b1, 16'hF0F0, 16'hFF00, 2'b01, 16'h0000, 16'h0000, 1'b0);
        tests++;
        if (bus.result !== 16'hFFF0 || bus.cout !== 1'b0) begin
            fails++;
            $display("FAIL or_op: got %h c=%b want FFF0 c=0", bus.result, bus.cout);
        end
        // a[2] stuck-at-0 on SUB: 0001-0003 vs 0005-0003
        cycle(1'b1, 16'h0005, 16'h0003, 2'b11, 16'h0004, 16'h0000, 1'b1);
        tests++;
        if (bus.result !== 16'hFFFE || bus.cout !== 1'b0 || bus.result_golden !== 16'h0002
            || bus.cout_golden !== 1'b1 || bus.mismatch !== 1'b1) begin
            fails++;
            $display("FAIL sub_fault: got %h c=%b g=%h cg=%b mm=%b want FFFE 0 0002 1 1",
                     bus.result, bus.cout, bus.result_golden, bus.cout_golden, bus.mismatch);
        end
        // Same fault, in_valid low: results still update, detection suppressed
        cycle(1'b0, 16'h0005, 16'h0003, 2'b11, 16'h0004, 16'h0000, 1'b0);
        tests++;
        if (bus.result !== 16'hFFFE || bus.result_golden !== 16'h0002 || bus.mismatch !== 1'b0
            || bus.out_valid !== 1'b0 || bus.detect_count !== exp_cnt) begin
            fails++;
            $display("FAIL invalid_gate: got %h g=%h mm=%b ov=%b cnt=%h want FFFE 0002 0 0 %h",
                     bus.result, bus.result_golden, bus.mismatch, bus.out_valid,
                     bus.detect_count, exp_cnt);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] a, b, af, bit_m;
        logic [16:0] sum;
        logic        em;
        int          n_mm = 0;
        logic [15:0] cnt_start = exp_cnt;
        for (int i = 0; i < 16; i++) begin
            a     = 16'($urandom);
            b     = 16'($urandom);
            bit_m = 16'h0001 << i;
            for (int sv = 0; sv < 2; sv++) begin
                af  = (sv == 1) ? (a | bit_m) : (a & ~bit_m);
                sum = {1'b0, af} + {1'b0, b};
                em  = (a[i] != sv[0]);
                if (em) n_mm++;
                cycle(1'b1, a, b, 2'b10, bit_m, (sv == 1) ? bit_m : 16'h0000, em);
                tests++;
                if ({bus.cout, bus.result} !== sum || bus.mismatch !== em
                    || bus.detect_count !== exp_cnt) begin
                    fails++;
                    $display("FAIL sweep bit%0d sa%0d: got %h c=%b mm=%b cnt=%h want %h c=%b mm=%b cnt=%h",
                             i, sv, bus.result, bus.cout, bus.mismatch, bus.detect_count,
                             sum[15:0], sum[16], em, exp_cnt);
                end
            end
        end
        // Flush the last lagged detection, then compare against the tally
        cycle(1'b1, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1'b0);
        tests++;
        if (bus.detect_count !== cnt_start + 16'(n_mm)) begin
            fails++;
            $display("FAIL sweep_total: got cnt=%h want %h", bus.detect_count,
                     cnt_start + 16'(n_mm));
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 65540; i++)
            cycle(1'b1, 16'hAAAA, 16'h5555, 2'b10, 16'h0020, 16'h0000, 1'b1);
        tests++;
        if (bus.detect_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL saturate_reach: got cnt=%h want FFFF", bus.detect_count);
        end
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 16'hAAAA, 16'h5555, 2'b10, 16'h0020, 16'h0000, 1'b1);
        tests++;
        if (bus.detect_count !== 16'hFFFF || bus.mismatch !== 1'b1) begin
            fails++;
            $display("FAIL saturate_hold: got cnt=%h mm=%b want FFFF mm=1",
                     bus.detect_count, bus.mismatch);
        end
    endtask

    task automatic test_midstream_reset();
        cycle(1'b1, 16'hAAAA, 16'h5555, 2'b10, 16'h0020, 16'h0000, 1'b1);
        rst = 1'b1;
        cycle(1'b1, 16'hAAAA, 16'h5555, 2'b10, 16'h0020, 16'h0000, 1'b1);
        tests++;
        if ({bus.result, bus.cout, bus.result_golden, bus.cout_golden, bus.out_valid,
             bus.mismatch} !== 36'h0 || bus.detect_count !== 16'h0000) begin
            fails++;
            $display("FAIL midreset_clear: got %h/%b/%h/%b ov=%b mm=%b cnt=%h want all 0",
                     bus.result, bus.cout, bus.result_golden, bus.cout_golden,
                     bus.out_valid, bus.mismatch, bus.detect_count);
        end
        rst = 1'b0;
        cycle(1'b1, 16'hAAAA, 16'h5555, 2'b10, 16'h0000, 16'h0000, 1'b0);
        tests++;
        if (bus.detect_count !== 16'h0000 || bus.result !== 16'hFFFF || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL midreset_resume: got cnt=%h res=%h ov=%b want 0000 FFFF 1",
                     bus.detect_count, bus.result, bus.out_valid);
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_no_fault();
        test_undetectable();
        test_detected();
        test_ops();
        test_sweep();
        test_saturate();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
